fetch_buffer: RTL and testbench

Instruction-fetch responder on the far side of the program counter register. Each cycle it takes the current fetch address, issues it to instruction memory, and tracks the in-order responses in a small queue. It presents (PC, instruction) pairs to decode with a valid/ready handshake. When the queue cannot accept a new fetch, it drives `fetch_stall` back to the PC register, and it discards everything in flight on a redirect.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_slot_queue.sv | 74 +++++++
 rtl/fetch_buffer.sv | 87 ++++++++
 tb/tb_fetch_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
// One slot holds a fetch address, its returned instruction and a filled flag.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order slot queue: allocate at tail, fill responses at fill, pop at head.
// A flush drops every slot and collapses all pointers onto tail.
module fetch_slot_queue import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [XLEN-1:0]         push_pc,
  input  logic                    fill_en,
  input  logic [XLEN-1:0]         fill_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [XLEN-1:0]         head_pc,
  output logic [XLEN-1:0]         head_instr,
  output logic                    head_filled,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  unfilled
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_slot_t   slots [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] fill;
  logic [PW-1:0] tail;
  logic [PW-1:0] gap;

  assign head_pc     = slots[head].pc;
  assign head_instr  = slots[head].instr;
  assign head_filled = slots[head].filled;
  assign gap         = tail - fill;

  // fill == tail is ambiguous only when every slot is allocated; the fill slot's flag decides it
  always_comb begin
    unfilled = {1'b0, gap};
    if (gap == '0 && count == CW'(DEPTH) && !slots[fill].filled)
      unfilled = CW'(DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      fill  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (flush) begin
      head  <= tail;
      fill  <= tail;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      if (push) begin
        slots[tail].pc     <= push_pc;
        slots[tail].instr  <= NOP_INSTR;
        slots[tail].filled <= 1'b0;
        tail               <= tail + 1'b1;
      end
      if (fill_en) begin
        slots[fill].instr  <= fill_data;
        slots[fill].filled <= 1'b1;
        fill               <= fill + 1'b1;
      end
      if (pop) begin
        slots[head].filled <= 1'b0;
        head               <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch responder: issues PC to memory, queues in-order responses
// for decode, stalls the PC register when full and discards flushed responses.
module fetch_buffer import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN  = fetch_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC,
  input  logic            redirect,
  output logic            fetch_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ID_valid,
  output logic [XLEN-1:0] ID_PC,
  output logic [XLEN-1:0] ID_instr,
  input  logic            ID_ready,
  output logic            fetch_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;
  logic            head_filled;
  logic [CW-1:0]   count;
  logic [CW-1:0]   unfilled;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   owed;
  logic            issue;
  logic            pop;
  logic            fill_en;

  // Owed responses to flushed requests still occupy memory-side capacity
  assign imem_req    = !rst && !redirect && ((count + discard) < CW'(DEPTH));
  assign issue       = imem_req && imem_gnt;
  assign fetch_stall = !issue;
  assign imem_addr   = PC;

  assign ID_valid = head_filled;
  assign ID_PC    = head_pc;
  assign ID_instr = head_instr;

  assign pop     = head_filled && ID_ready && !redirect;
  assign fill_en = imem_rvalid && !redirect && (discard == '0) && (unfilled != '0);
  assign owed    = discard + unfilled;

  fetch_slot_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (issue),
    .push_pc     (PC),
    .fill_en     (fill_en),
    .fill_data   (imem_rdata),
    .pop         (pop),
    .flush       (redirect),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .head_filled (head_filled),
    .count       (count),
    .unfilled    (unfilled)
  );

  // A response landing in the redirect cycle pays off one of the owed responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard   <= '0;
      fetch_err <= 1'b0;
    end else if (redirect) begin
      if (imem_rvalid && owed == '0) begin
        discard   <= '0;
        fetch_err <= 1'b1;
      end else begin
        discard <= owed - CW'(imem_rvalid);
      end
    end else if (imem_rvalid) begin
      if (discard != '0)
        discard <= discard - CW'(1);
      else if (unfilled == '0)
        fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH = 4, 1-cycle memory model).
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        redirect;
  logic        fetch_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ID_valid;
  logic [31:0] ID_PC;
  logic [31:0] ID_instr;
  logic        ID_ready;
  logic        fetch_err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        mem_auto;
  logic        last_issued;
  logic [31:0] last_addr;
  int          issue_count;

  fetch_buffer #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .PC(PC), .redirect(redirect),
    .fetch_stall(fetch_stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ID_valid(ID_valid), .ID_PC(ID_PC), .ID_instr(ID_instr),
    .ID_ready(ID_ready), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  // Entered at posedge+1; samples the issue just before the next edge, then
  // returns at the following posedge+1 with the 1-cycle memory response driven.
  task automatic tick();
    logic        iss;
    logic [31:0] a;
    #2;
    iss = imem_req && imem_gnt;
    a   = imem_addr;
    @(posedge clk);
    #1;
    last_issued = iss;
    last_addr   = a;
    if (iss) issue_count++;
    if (mem_auto) begin
      imem_rvalid = iss;
      imem_rdata  = iss ? instr_of(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; ID_ready = 1'b0; mem_auto = 1'b0; PC = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_stall: got %b want 1", fetch_stall); end
    n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", ID_valid); end
    n_checks++; if (ID_PC !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_idpc: got %h want 0", ID_PC); end
    n_checks++; if (ID_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_idinstr: got %h want 0", ID_instr); end
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", fetch_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_release_req: got %b want 1", imem_req); end
  endtask

  task automatic test_streaming();
    do_reset();
    mem_auto = 1'b1; imem_gnt = 1'b1; ID_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_stall[%0d]: got %b want 0", i, fetch_stall); end
      n_checks++; if (ID_valid !== (i >= 2)) begin n_fail++; $display("[TB] FAIL stream_valid[%0d]: got %b want %b", i, ID_valid, (i >= 2)); end
      if (i >= 2) begin
        n_checks++; if (ID_PC !== 32'(4 * (i - 2))) begin n_fail++; $display("[TB] FAIL stream_pc[%0d]: got %h want %h", i, ID_PC, 32'(4 * (i - 2))); end
        n_checks++; if (ID_instr !== instr_of(32'(4 * (i - 2)))) begin n_fail++; $display("[TB] FAIL stream_instr[%0d]: got %h want %h", i, ID_instr, instr_of(32'(4 * (i - 2)))); end
      end
      tick();
      if (last_issued) PC = PC + 32'd4;
    end
  endtask

  task automatic test_decode_stall();
    do_reset();
    mem_auto = 1'b1; imem_gnt = 1'b1; ID_ready = 1'b0;
    issue_count = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if (fetch_stall !== (i >= 4)) begin n_fail++; $display("[TB] FAIL dstall_stall[%0d]: got %b want %b", i, fetch_stall, (i >= 4)); end
      tick();
      if (last_issued) PC = PC + 32'd4;
    end
    n_checks++; if (issue_count !== 4) begin n_fail++; $display("[TB] FAIL dstall_issues: got %0d want 4", issue_count); end
    n_checks++; if (PC !== 32'h10) begin n_fail++; $display("[TB] FAIL dstall_nextpc: got %h want 10", PC); end
    n_checks++; if (ID_valid !== 1'b1 || ID_PC !== 32'h0) begin n_fail++; $display("[TB] FAIL dstall_head: got valid %b pc %h want 1 0", ID_valid, ID_PC); end
    ID_ready = 1'b1;
    #1;
    n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL dstall_nobypass: got %b want 1", fetch_stall); end
    tick();
    ID_ready = 1'b0;
    #1;
    n_checks++; if (ID_PC !== 32'h4) begin n_fail++; $display("[TB] FAIL dstall_pop: got %h want 4", ID_PC); end
    n_checks++; if (fetch_stall !== 1'b0 || imem_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL dstall_resume: got stall %b addr %h want 0 10", fetch_stall, imem_addr); end
    tick();
    n_checks++; if (last_issued !== 1'b1 || last_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL dstall_issue10: got %b %h want 1 10", last_issued, last_addr); end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    imem_gnt = 1'b1;
    PC = 32'h0; tick();
    PC = 32'h4; tick();
    PC = 32'h8; tick();
    redirect = 1'b1; PC = 32'h200;
    #1;
    n_checks++; if (imem_req !== 1'b0 || fetch_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_noissue: got req %b stall %b want 0 1", imem_req, fetch_stall); end
    tick();
    redirect = 1'b0;
    n_checks++; if (dut.discard !== 3'd3) begin n_fail++; $display("[TB] FAIL redir_discard: got %0d want 3", dut.discard); end
    n_checks++; if (dut.count !== 3'd0) begin n_fail++; $display("[TB] FAIL redir_count: got %0d want 0", dut.count); end
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_newreq: got %b want 1", imem_req); end
    tick();
    imem_gnt = 1'b0;
    n_checks++; if (last_issued !== 1'b1 || last_addr !== 32'h200) begin n_fail++; $display("[TB] FAIL redir_target: got %b %h want 1 200", last_issued, last_addr); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_stale[%0d]: got %b want 0", i, ID_valid); end
      if (i < 2) tick();
    end
    n_checks++; if (dut.discard !== 3'd0) begin n_fail++; $display("[TB] FAIL redir_paid: got %0d want 0", dut.discard); end
    imem_rdata = instr_of(32'h200);
    tick();
    imem_rvalid = 1'b0;
    n_checks++; if (ID_valid !== 1'b1 || ID_PC !== 32'h200) begin n_fail++; $display("[TB] FAIL redir_out: got valid %b pc %h want 1 200", ID_valid, ID_PC); end
    n_checks++; if (ID_instr !== instr_of(32'h200)) begin n_fail++; $display("[TB] FAIL redir_instr: got %h want %h", ID_instr, instr_of(32'h200)); end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    imem_gnt = 1'b1;
    PC = 32'h0; tick();
    PC = 32'h4; tick();
    imem_gnt = 1'b0;
    redirect = 1'b1; PC = 32'h300; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h0);
    tick();
    redirect = 1'b0; imem_rdata = instr_of(32'h4);
    n_checks++; if (dut.discard !== 3'd1) begin n_fail++; $display("[TB] FAIL coin_discard: got %0d want 1", dut.discard); end
    n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL coin_valid0: got %b want 0", ID_valid); end
    tick();
    imem_rvalid = 1'b0;
    n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL coin_valid1: got %b want 0", ID_valid); end
    n_checks++; if (dut.discard !== 3'd0 || fetch_err !== 1'b0) begin n_fail++; $display("[TB] FAIL coin_end: got discard %0d err %b want 0 0", dut.discard, fetch_err); end
  endtask

  task automatic test_spurious();
    do_reset();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("[TB] FAIL spur_pre: got %b want 0", fetch_err); end
    tick();
    imem_rvalid = 1'b0;
    n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_err: got %b want 1", fetch_err); end
    n_checks++; if (ID_valid !== 1'b0 || dut.count !== 3'd0 || dut.discard !== 3'd0) begin n_fail++; $display("[TB] FAIL spur_state: got valid %b count %0d discard %0d want 0 0 0", ID_valid, dut.count, dut.discard); end
    tick();
    tick();
    n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_sticky: got %b want 1", fetch_err); end
  endtask

  task automatic test_async_reset();
    mem_auto = 1'b1; imem_gnt = 1'b1; ID_ready = 1'b1; PC = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (last_issued) PC = PC + 32'd4;
    end
    n_checks++; if (ID_valid !== 1'b1 || fetch_err !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_pre: got valid %b err %b want 1 1", ID_valid, fetch_err); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (ID_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_out: got valid %b req %b want 0 0", ID_valid, imem_req); end
    n_checks++; if (fetch_err !== 1'b0 || fetch_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_err: got err %b stall %b want 0 1", fetch_err, fetch_stall); end
    n_checks++; if (dut.count !== 3'd0 || dut.discard !== 3'd0) begin n_fail++; $display("[TB] FAIL areset_cnt: got count %0d discard %0d want 0 0", dut.count, dut.discard); end
    @(posedge clk);
    #1;
    rst = 1'b0; mem_auto = 1'b0; imem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; PC = 32'h0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; ID_ready = 1'b0; mem_auto = 1'b0;
    last_issued = 1'b0; last_addr = 32'h0; issue_count = 0;
    test_reset();
    test_streaming();
    test_decode_stall();
    test_redirect_discard();
    test_redirect_coincident();
    test_spurious();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
